// File: rtl/filter_buffer_pkg.sv
// Shared constants for the filter buffer: data/address widths, bank count and write FSM encodings.
package filter_buffer_pkg;
  localparam int FILTER_DW        = 72;
  localparam int FILTER_BUFFER_AW = 7;
  localparam int Tout             = 4;

  localparam logic [1:0] FB_ST_IDLE = 2'd0;
  localparam logic [1:0] FB_ST_LOAD = 2'd1;
  localparam logic [1:0] FB_ST_FULL = 2'd2;
endpackage

// File: rtl/filter_buffer_bank_ram.sv
// One bank of one half: simple dual-port RAM, registered read that holds when no read is issued.
module fb_bank_ram #(
  parameter int DW = 72,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];

  assign rdata_o = rdata_q;
endmodule

// File: rtl/filter_buffer.sv
// Ping-pong filter buffer: loads the shadow half from a stream while the PE reads the active half.
module filter_buffer #(
  parameter int FILTER_DW     = filter_buffer_pkg::FILTER_DW,
  parameter int FILTER_BUF_AW = filter_buffer_pkg::FILTER_BUFFER_AW,
  parameter int Tout          = filter_buffer_pkg::Tout
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_load_start,
  input  logic [FILTER_BUF_AW:0]   i_load_words,
  input  logic                     s_valid,
  input  logic [FILTER_DW-1:0]     s_data,
  output logic                     s_ready,
  output logic                     o_load_done,
  output logic                     o_shadow_full,
  input  logic                     i_swap,
  output logic                     o_swap_ack,
  input  logic                     i_fb_req,
  input  logic [FILTER_BUF_AW-1:0] i_fb_addr,
  output logic [FILTER_DW-1:0]     o_fb_data0,
  output logic [FILTER_DW-1:0]     o_fb_data1,
  output logic [FILTER_DW-1:0]     o_fb_data2,
  output logic [FILTER_DW-1:0]     o_fb_data3,
  output logic                     o_fb_vld
);
  import filter_buffer_pkg::*;

  localparam int AW = FILTER_BUF_AW;
  localparam int CW = AW + 3;

  logic [1:0]    state_q, state_d;
  logic          act_q, act_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          ract_q;
  logic          vld_q;
  logic          hs, last, start_load;

  logic [1:0][Tout-1:0]            we;
  logic [1:0][Tout-1:0][FILTER_DW-1:0] rdata;

  assign hs   = (state_q == FB_ST_LOAD) && s_valid;
  assign last = (wcnt_q == ({len_q, 2'b00} - CW'(1)));

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    done_d     = 1'b0;
    ack_d      = 1'b0;
    start_load = 1'b0;
    case (state_q)
      FB_ST_IDLE: start_load = i_load_start;
      FB_ST_LOAD: if (hs) begin
        wcnt_d = wcnt_q + CW'(1);
        if (last) begin
          state_d = FB_ST_FULL;
          done_d  = 1'b1;
        end
      end
      FB_ST_FULL: if (i_swap) begin
        act_d      = ~act_q;
        ack_d      = 1'b1;
        state_d    = FB_ST_IDLE;
        start_load = i_load_start;
      end
      default: state_d = FB_ST_IDLE;
    endcase
    // A swap and a new load may share the edge; the load then targets the freshly demoted half.
    if (start_load) begin
      if (i_load_words == '0) begin
        state_d = FB_ST_FULL;
        done_d  = 1'b1;
      end else begin
        state_d = FB_ST_LOAD;
        len_d   = i_load_words;
        wcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= FB_ST_IDLE;
      act_q   <= 1'b0;
      len_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      ract_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      vld_q   <= i_fb_req;
      if (i_fb_req) ract_q <= act_q;
    end

  for (genvar h = 0; h < 2; h++) begin : g_half
    for (genvar b = 0; b < Tout; b++) begin : g_bank
      assign we[h][b] = hs && (act_q != 1'(h)) && (wcnt_q[1:0] == 2'(b));
      fb_bank_ram #(.DW(FILTER_DW), .AW(AW)) u_ram (
        .clk    (clk),
        .rstn   (rstn),
        .we_i   (we[h][b]),
        .waddr_i(wcnt_q[AW+1:2]),
        .wdata_i(s_data),
        .re_i   (i_fb_req),
        .raddr_i(i_fb_addr),
        .rdata_o(rdata[h][b])
      );
    end
  end

  assign s_ready       = (state_q == FB_ST_LOAD);
  assign o_shadow_full = (state_q == FB_ST_FULL);
  assign o_load_done   = done_q;
  assign o_swap_ack    = ack_q;
  assign o_fb_vld      = vld_q;
  assign o_fb_data0    = rdata[ract_q][0];
  assign o_fb_data1    = rdata[ract_q][1];
  assign o_fb_data2    = rdata[ract_q][2];
  assign o_fb_data3    = rdata[ract_q][3];
endmodule

// File: tb/tb_filter_buffer.sv
// Self-checking bench: behavioural ping-pong model checked every cycle, plus a fixed read-back table.
module tb_filter_buffer;
  localparam int DW = 72;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_load_start, s_valid, i_swap, i_fb_req;
  logic [AW:0]   i_load_words;
  logic [DW-1:0] s_data;
  logic [AW-1:0] i_fb_addr;
  logic          s_ready, o_load_done, o_shadow_full, o_swap_ack, o_fb_vld;
  logic [DW-1:0] o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3;

  always #5 clk = ~clk;

  filter_buffer dut (
    .clk(clk), .rstn(rstn),
    .i_load_start(i_load_start), .i_load_words(i_load_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_load_done(o_load_done), .o_shadow_full(o_shadow_full),
    .i_swap(i_swap), .o_swap_ack(o_swap_ack),
    .i_fb_req(i_fb_req), .i_fb_addr(i_fb_addr),
    .o_fb_data0(o_fb_data0), .o_fb_data1(o_fb_data1),
    .o_fb_data2(o_fb_data2), .o_fb_data3(o_fb_data3),
    .o_fb_vld(o_fb_vld)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: two halves of four banks, a stream index and two status flags.
  logic [DW-1:0] mem [2][4][128];
  int  m_act, m_k, m_len;
  bit  m_loading, m_full;
  logic e_ready, e_done, e_full, e_ack, e_vld;
  logic [3:0][DW-1:0] e_d;

  typedef struct {
    logic [AW-1:0]      addr;
    logic [3:0][DW-1:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    m_act = 0; m_k = 0; m_len = 0; m_loading = 0; m_full = 0;
    e_ready = 0; e_done = 0; e_full = 0; e_ack = 0; e_vld = 0; e_d = '0;
  endtask

  task automatic model_begin_load();
    if (i_load_words == 0) begin
      m_full = 1; e_done = 1;
    end else begin
      m_loading = 1; m_len = int'(i_load_words); m_k = 0;
    end
  endtask

  task automatic model_step();
    e_done = 0; e_ack = 0;
    e_vld = i_fb_req;
    if (i_fb_req)
      for (int b = 0; b < 4; b++) e_d[b] = mem[m_act][b][i_fb_addr];
    if (m_loading) begin
      if (s_valid) begin
        mem[1-m_act][m_k%4][m_k/4] = s_data;
        m_k++;
        if (m_k == 4*m_len) begin m_loading = 0; m_full = 1; e_done = 1; end
      end
    end else if (m_full) begin
      if (i_swap) begin
        m_act = 1 - m_act; e_ack = 1; m_full = 0;
        if (i_load_start) model_begin_load();
      end
    end else if (i_load_start) begin
      model_begin_load();
    end
    e_ready = m_loading; e_full = m_full;
  endtask

  task automatic cmp_all();
    chk("s_ready", DW'(s_ready), DW'(e_ready));
    chk("load_done", DW'(o_load_done), DW'(e_done));
    chk("shadow_full", DW'(o_shadow_full), DW'(e_full));
    chk("swap_ack", DW'(o_swap_ack), DW'(e_ack));
    chk("fb_vld", DW'(o_fb_vld), DW'(e_vld));
    chk("fb_data0", o_fb_data0, e_d[0]);
    chk("fb_data1", o_fb_data1, e_d[1]);
    chk("fb_data2", o_fb_data2, e_d[2]);
    chk("fb_data3", o_fb_data3, e_d[3]);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    cmp_all();
    i_load_start = 0; i_swap = 0;
  endtask

  // Random read of the active half within its known-written range.
  task automatic rd(int lim);
    if (lim > 0) begin
      i_fb_req  = ($urandom_range(0, 3) != 0);
      i_fb_addr = AW'($urandom_range(0, lim-1));
    end else i_fb_req = 0;
  endtask

  task automatic do_load(bit pulse, int words, bit rand_valid, bit rand_data,
                         bit swap_mid, int abort_at, int lim, output int ndone);
    ndone = 0;
    if (pulse) begin
      i_load_start = 1; i_load_words = (AW+1)'(words); rd(lim); cyc();
    end
    for (int n = 0; n < 3000 && m_loading; n++) begin
      if (abort_at >= 0 && m_k == abort_at) break;
      s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = rand_data ? rnd72() : DW'(m_k);
      if (swap_mid && n == 5) i_swap = 1;
      if (swap_mid && n == 6) i_load_start = 1;
      rd(lim); cyc();
      if (o_load_done) ndone++;
    end
    s_valid = 0;
    if (m_loading && abort_at < 0) begin
      failures++; checks++;
      $display("FAIL load_timeout: still loading at %0d of %0d words", m_k, 4*m_len);
    end
  endtask

  task automatic do_swap(int lim);
    i_swap = 1; rd(lim); cyc();
    chk("swap_ack_pulse", DW'(o_swap_ack), DW'(1));
  endtask

  task automatic table_check(string tag);
    for (int i = 0; i < 8; i++) begin
      i_fb_req = 1; i_fb_addr = tbl[i].addr; cyc();
      chk({tag, "_vld"}, DW'(o_fb_vld), DW'(1));
      chk({tag, "_d0"}, o_fb_data0, tbl[i].exp[0]);
      chk({tag, "_d1"}, o_fb_data1, tbl[i].exp[1]);
      chk({tag, "_d2"}, o_fb_data2, tbl[i].exp[2]);
      chk({tag, "_d3"}, o_fb_data3, tbl[i].exp[3]);
    end
    i_fb_req = 0; cyc();
    chk({tag, "_idle_vld"}, DW'(o_fb_vld), DW'(0));
    chk({tag, "_hold_d3"}, o_fb_data3, tbl[7].exp[3]);
  endtask

  initial begin
    int nd;
    for (int a = 0; a < 8; a++) begin
      tbl[a].addr = AW'(a);
      for (int j = 0; j < 4; j++) tbl[a].exp[j] = DW'(4*a + j);
    end
    rstn = 0; i_load_start = 0; i_load_words = '0; s_valid = 0; s_data = '0;
    i_swap = 0; i_fb_req = 0; i_fb_addr = '0;
    model_reset();
    #12; cmp_all();
    @(negedge clk); rstn = 1;
    cyc();

    // Basic load of 8 entries, data = stream index
    do_load(1, 8, 0, 0, 0, -1, 0, nd);
    chk("basic_done_count", DW'(nd), DW'(1));
    do_swap(0);
    table_check("basic");

    // Swap request while idle is ignored
    i_swap = 1; rd(8); cyc();
    chk("swap_idle_ack", DW'(o_swap_ack), DW'(0));

    // Backpressured 12-entry load with a swap and a stray start mid-load, reading old half meanwhile
    do_load(1, 12, 1, 0, 1, -1, 8, nd);
    chk("bp_done_count", DW'(nd), DW'(1));
    do_swap(8);
    table_check("bp");

    // Overlap: random 6-entry load, then swap and start together
    do_load(1, 6, 1, 1, 0, -1, 12, nd);
    for (int i = 0; i < 3; i++) begin rd(12); cyc(); end
    i_swap = 1; i_load_start = 1; i_load_words = (AW+1)'(5);
    i_fb_req = 1; i_fb_addr = AW'(3); cyc();
    chk("ovl_ack", DW'(o_swap_ack), DW'(1));
    i_fb_req = 1; i_fb_addr = AW'(3); cyc();
    chk("ovl_in_load", DW'(s_ready), DW'(1));
    do_load(0, 5, 1, 1, 0, -1, 6, nd);
    do_swap(6);
    for (int i = 0; i < 20; i++) begin rd(12); cyc(); end

    // Zero-length load
    i_load_start = 1; i_load_words = '0; rd(12); cyc();
    chk("zero_done", DW'(o_load_done), DW'(1));
    chk("zero_full", DW'(o_shadow_full), DW'(1));
    chk("zero_ready", DW'(s_ready), DW'(0));
    rd(12); cyc();
    chk("zero_done_pulse", DW'(o_load_done), DW'(0));
    do_swap(12);

    // Reset after 10 words of a load
    do_load(1, 8, 0, 1, 0, 10, 6, nd);
    #1 rstn = 0; model_reset(); #2;
    cmp_all();
    chk("rst_ready", DW'(s_ready), DW'(0));
    @(negedge clk); rstn = 1;
    for (int i = 0; i < 16; i++) begin rd(12); cyc(); end
    do_load(1, 8, 0, 0, 0, -1, 12, nd);
    chk("post_rst_done_count", DW'(nd), DW'(1));
    do_swap(12);
    table_check("post_rst");
    for (int i = 0; i < 40; i++) begin rd(8); cyc(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
